// File: rtl/serial_logic_pkg.sv
// serial_logic_pkg: shared states, op encoding and counter sizing for the bit-serial logic units.
package serial_logic_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} serial_state_t;
  typedef enum logic {OP_OR, OP_AND} serial_op_t;
  function automatic int cnt_width(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction
endpackage

// File: rtl/or_slice.sv
// or_slice: combinational SLICE-bit OR; AND alternative when SERIAL_OR16_OP_SELECT_EN is defined.
module or_slice
  import serial_logic_pkg::*;
#(
  parameter int SLICE = 1
) (
`ifdef SERIAL_OR16_OP_SELECT_EN
  input  serial_op_t       i_op,
`endif
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  output logic [SLICE-1:0] o_y
);
`ifdef SERIAL_OR16_OP_SELECT_EN
  assign o_y = (i_op == OP_AND) ? (i_a & i_b) : (i_a | i_b);
`else
  assign o_y = i_a | i_b;
`endif
endmodule

// File: rtl/serial_or16.sv
// serial_or16: bit-serial WIDTH-bit OR over valid/ready handshakes, SLICE bits per cycle.
// Optional SERIAL_OR16_OP_SELECT_EN adds an 'op' input selecting OR (0) or AND (1).
module serial_or16
  import serial_logic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
`ifdef SERIAL_OR16_OP_SELECT_EN
  input  logic             op,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy
);
  localparam int STEPS = WIDTH / SLICE;
  localparam int CW = cnt_width(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);
  serial_state_t    r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sa, r_sb, r_res, r_out, w_res_next;
  logic [SLICE-1:0] w_slice;
  logic             w_accept, w_last;
`ifdef SERIAL_OR16_OP_SELECT_EN
  serial_op_t       r_op;
`endif
  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last = (r_cnt == LAST);
  or_slice #(.SLICE(SLICE)) u_slice (
`ifdef SERIAL_OR16_OP_SELECT_EN
    .i_op(r_op),
`endif
    .i_a(r_sa[SLICE-1:0]),
    .i_b(r_sb[SLICE-1:0]),
    .o_y(w_slice)
  );
  // LSB-first: each new slice enters at the MSB end and older slices move down
  assign w_res_next = WIDTH'({w_slice, r_res} >> SLICE);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = in_valid ? SHIFT : IDLE;
      SHIFT:   w_next = w_last ? DONE : SHIFT;
      DONE:    w_next = out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sa    <= '0;
      r_sb    <= '0;
      r_res   <= '0;
      r_out   <= '0;
`ifdef SERIAL_OR16_OP_SELECT_EN
      r_op    <= OP_OR;
`endif
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_sa  <= a;
        r_sb  <= b;
        r_res <= '0;
        r_cnt <= '0;
`ifdef SERIAL_OR16_OP_SELECT_EN
        r_op  <= serial_op_t'(op);
`endif
      end else if (r_state == SHIFT) begin
        r_sa  <= r_sa >> SLICE;
        r_sb  <= r_sb >> SLICE;
        r_res <= w_res_next;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) r_out <= w_res_next;
      end
    end
  end
  // out only updates on completion, so it holds through acceptance until the next result
  assign out       = r_out;
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == SHIFT);
endmodule

// File: tb/tb_serial_or16.sv
// tb_serial_or16: directed scoreboard bench for serial_or16 at SLICE=1 and SLICE=4.
module tb_serial_or16;
  logic clk = 0, reset_n = 0;
  logic in_valid = 0, in_valid4 = 0, out_ready = 1, out_ready4 = 1;
  logic [15:0] a = '0, b = '0;
`ifdef SERIAL_OR16_OP_SELECT_EN
  logic op = 0;
`endif
  logic in_ready, out_valid, busy, in_ready4, out_valid4, busy4;
  logic [15:0] out, out4;
  int total = 0, bad = 0, cyc = 0;
  int acc1 = 0, acc4 = 0, gap1 = 0, gap4 = 0, lat1 = 0, lat4 = 0, lat = 0;
  logic [15:0] q[$], q4[$];
  always #5 clk = ~clk;
  serial_or16 #(.WIDTH(16), .SLICE(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
`ifdef SERIAL_OR16_OP_SELECT_EN
    .op(op),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .busy(busy)
  );
  serial_or16 #(.WIDTH(16), .SLICE(4)) dut4 (
    .clk(clk), .reset_n(reset_n),
`ifdef SERIAL_OR16_OP_SELECT_EN
    .op(op),
`endif
    .in_valid(in_valid4), .in_ready(in_ready4), .a(a), .b(b),
    .out_valid(out_valid4), .out_ready(out_ready4), .out(out4), .busy(busy4)
  );
  function automatic logic [15:0] model(input logic [15:0] x, input logic [15:0] y);
`ifdef SERIAL_OR16_OP_SELECT_EN
    return op ? (x & y) : (x | y);
`else
    return x | y;
`endif
  endfunction
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  always @(posedge clk) begin
    cyc++;
    if (!reset_n) begin
      q.delete();
      q4.delete();
    end else begin
      if (out_valid && out_ready) begin
        lat1 = cyc - acc1;
        total++;
        assert (q.size() > 0) else begin
          bad++;
          $error("FAIL dut1_extra_result observed=%h expected=none", out);
        end
        if (q.size() > 0) check("dut1_data", out, q.pop_front());
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b));
        gap1 = cyc - acc1;
        acc1 = cyc;
      end
      if (out_valid4 && out_ready4) begin
        lat4 = cyc - acc4;
        total++;
        assert (q4.size() > 0) else begin
          bad++;
          $error("FAIL dut4_extra_result observed=%h expected=none", out4);
        end
        if (q4.size() > 0) check("dut4_data", out4, q4.pop_front());
      end
      if (in_valid4 && in_ready4) begin
        q4.push_back(model(a, b));
        gap4 = cyc - acc4;
        acc4 = cyc;
      end
    end
  end
  task automatic txn(input logic [15:0] xa, input logic [15:0] xb, input bit scramble, output int n);
    a = xa;
    b = xb;
    in_valid = 1;
    check("ready_before_accept", {15'b0, in_ready}, 16'd1);
    @(posedge clk); #1;
    in_valid = 0;
    check("busy_after_accept", {15'b0, busy}, 16'd1);
    n = 0;
    while (!out_valid && n < 40) begin
      if (scramble) begin
        a = 16'($urandom);
        b = 16'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
  endtask
  task automatic consume(input logic [15:0] exp);
    @(posedge clk); #1;
    check("valid_drop", {15'b0, out_valid}, 16'd0);
    check("ready_back", {15'b0, in_ready}, 16'd1);
    check("out_retained", out, exp);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {15'b0, in_ready}, 16'd1);
    check("rst_out_valid", {15'b0, out_valid}, 16'd0);
    check("rst_out", out, 16'h0000);
    check("rst_busy", {15'b0, busy}, 16'd0);
    check("rst_in_ready4", {15'b0, in_ready4}, 16'd1);
    reset_n = 1;
    @(posedge clk); #1;
    txn(16'h00F0, 16'h0F01, 0, lat);
    check("basic_latency", 16'(lat), 16'd16);
    check("basic_out", out, 16'h0FF1);
    check("basic_no_ready", {15'b0, in_ready}, 16'd0);
    consume(16'h0FF1);
    out_ready = 0;
    txn(16'hAAAA, 16'h5555, 0, lat);
    check("bp_latency", 16'(lat), 16'd16);
    for (int i = 0; i < 10; i++) begin
      check("bp_out", out, 16'hFFFF);
      check("bp_valid", {15'b0, out_valid}, 16'd1);
      check("bp_in_ready", {15'b0, in_ready}, 16'd0);
      @(posedge clk); #1;
    end
    out_ready = 1;
    consume(16'hFFFF);
    a = 16'h1111;
    b = 16'h2222;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (7) @(posedge clk);
    #1;
    check("mid_busy", {15'b0, busy}, 16'd1);
    reset_n = 0;
    @(posedge clk); #1;
    check("mid_rst_in_ready", {15'b0, in_ready}, 16'd1);
    check("mid_rst_out_valid", {15'b0, out_valid}, 16'd0);
    check("mid_rst_out", out, 16'h0000);
    check("mid_rst_busy", {15'b0, busy}, 16'd0);
    reset_n = 1;
    repeat (20) @(posedge clk);
    #1;
    check("dropped_txn_valid", {15'b0, out_valid}, 16'd0);
    txn(16'h0000, 16'h8000, 0, lat);
    check("post_rst_latency", 16'(lat), 16'd16);
    check("post_rst_out", out, 16'h8000);
    consume(16'h8000);
    txn(16'h1234, 16'h4321, 1, lat);
    check("hold_latency", 16'(lat), 16'd16);
    check("hold_out", out, 16'h5335);
    consume(16'h5335);
    in_valid = 1;
    for (int i = 0; i < 18 * 3 + 5; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      check("never_both", {15'b0, in_ready & out_valid}, 16'd0);
      @(posedge clk); #1;
    end
    in_valid = 0;
    repeat (20) @(posedge clk);
    #1;
    check("b2b_gap1", 16'(gap1), 16'd18);
    check("b2b_lat1", 16'(lat1), 16'd17);
    in_valid4 = 1;
    for (int i = 0; i < 6 * 4 + 3; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      @(posedge clk); #1;
    end
    in_valid4 = 0;
    repeat (10) @(posedge clk);
    #1;
    check("b2b_gap4", 16'(gap4), 16'd6);
    check("b2b_lat4", 16'(lat4), 16'd5);
`ifdef SERIAL_OR16_OP_SELECT_EN
    op = 1;
    txn(16'hFF0F, 16'h0FFF, 0, lat);
    check("op_and_out", out, 16'h0F0F);
    consume(16'h0F0F);
    op = 0;
    txn(16'hFF0F, 16'h0FFF, 0, lat);
    check("op_or_out", out, 16'hFFFF);
    consume(16'hFFFF);
`endif
    check("scoreboard_empty", 16'(q.size() + q4.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
